// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard-controller state type and constants
package pipe_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, INTERLOCK = 2'd1, FROZEN = 2'd2, FLUSH = 2'd3} hz_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MDU_LATENCY_DEF = 8;
endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: per-register pending bits for outstanding load/MDU results
module hz_scoreboard
    import pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        set_en,
    input  logic [4:0]  set_reg,
    input  logic        clr_en,
    input  logic [4:0]  clr_reg,
    input  logic        fl_en,
    input  logic [4:0]  fl_reg,
    output logic [31:0] pending
);
    logic [31:0] sb, sb_next;
    // Writeback and flush clears apply first so a same-cycle set wins; r0 never pends
    always_comb begin
        sb_next = sb;
        if (clr_en) sb_next[clr_reg] = 1'b0;
        if (fl_en) sb_next[fl_reg] = 1'b0;
        if (set_en && set_reg != REG_ZERO) sb_next[set_reg] = 1'b1;
        sb_next[0] = 1'b0;
    end
    // Scoreboard register
    always_ff @(posedge clock) begin
        if (!reset_n) sb <= '0;
        else sb <= sb_next;
    end
    assign pending = sb;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode-stage stall/bubble/flush control; HAZARD_STATS_EN adds event counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_writes,
    input  logic        id_is_load,
    input  logic        id_is_mdu,
    input  logic        ex_stall_c,
    input  logic        mem_stall_c,
    input  logic        EX_MEM_changePC_c,
    input  logic        WB_WEenable,
    input  logic [4:0]  WB_dest,
    output logic        if_stall_c,
    output logic        id_bubble_c,
    output logic        flush_c,
    output logic        mdu_busy,
    output logic [31:0] sb_pending,
    output logic [1:0]  hz_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stat_interlock_cycles,
    output logic [31:0] stat_flushes
`endif
);
    logic [3:0] mdu_cnt;
    logic       last_v, last_mdu;
    logic [4:0] last_dest;
    hz_state_t  state, state_next;
    logic       raw_rs, raw_rt, waw, strct, hazard, ext, issue, sb_set;

    // A pending register still forwards when its writeback is presented this cycle
    assign raw_rs = id_uses_rs && id_rs != REG_ZERO && sb_pending[id_rs] && !(WB_WEenable && WB_dest == id_rs);
    assign raw_rt = id_uses_rt && id_rt != REG_ZERO && sb_pending[id_rt] && !(WB_WEenable && WB_dest == id_rt);
    assign waw = id_writes && id_dest != REG_ZERO && sb_pending[id_dest] && !(WB_WEenable && WB_dest == id_dest);
    assign strct = id_is_mdu && mdu_busy;
    assign hazard = id_valid && (raw_rs || raw_rt || waw || strct);
    assign ext = ex_stall_c || mem_stall_c;
    assign flush_c = EX_MEM_changePC_c;
    assign if_stall_c = !flush_c && (ext || hazard);
    assign id_bubble_c = !flush_c && !ext && hazard;
    assign issue = id_valid && !flush_c && !ext && !hazard;
    assign sb_set = issue && id_writes && (id_is_load || id_is_mdu) && id_dest != REG_ZERO;
    assign mdu_busy = mdu_cnt != 4'd0;
    assign hz_state = state;

    hz_scoreboard u_sb (
        .clock   (clock),
        .reset_n (reset_n),
        .set_en  (sb_set),
        .set_reg (id_dest),
        .clr_en  (WB_WEenable),
        .clr_reg (WB_dest),
        .fl_en   (flush_c && last_v),
        .fl_reg  (last_dest),
        .pending (sb_pending)
    );

    // MDU occupancy: reload on issue, abandon a just-issued op on flush, else count down
    always_ff @(posedge clock) begin
        if (!reset_n) mdu_cnt <= '0;
        else if (issue && id_is_mdu) mdu_cnt <= 4'(MDU_LATENCY - 1);
        else if (flush_c && last_v && last_mdu) mdu_cnt <= '0;
        else if (mdu_busy) mdu_cnt <= mdu_cnt - 4'd1;
    end

    // Remember the previous cycle's scoreboard-setting issue so a flush can undo it
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_v    <= 1'b0;
            last_dest <= REG_ZERO;
            last_mdu  <= 1'b0;
        end else begin
            last_v    <= sb_set;
            last_dest <= id_dest;
            last_mdu  <= id_is_mdu;
        end
    end

    // Next state chosen purely from this cycle's conditions, highest priority first
    always_comb begin
        state_next = RUN;
        state_next = flush_c ? FLUSH : ext ? FROZEN : hazard ? INTERLOCK : RUN;
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= RUN;
        else state <= state_next;
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_interlock_cycles <= '0;
            stat_flushes          <= '0;
        end else begin
            if (state_next == INTERLOCK && stat_interlock_cycles != 32'hFFFF_FFFF)
                stat_interlock_cycles <= stat_interlock_cycles + 32'd1;
            if (flush_c && stat_flushes != 32'hFFFF_FFFF)
                stat_flushes <= stat_flushes + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, directed corner sequences and random stimulus vs a reference model
module tb_pipe_hazard_ctrl;
    localparam int L = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid, id_uses_rs, id_uses_rt, id_writes, id_is_load, id_is_mdu;
    logic [4:0]  id_rs, id_rt, id_dest, WB_dest;
    logic        ex_stall_c, mem_stall_c, EX_MEM_changePC_c, WB_WEenable;
    logic        if_stall_c, id_bubble_c, flush_c, mdu_busy;
    logic [31:0] sb_pending;
    logic [1:0]  hz_state;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_interlock_cycles, stat_flushes;
`endif

    pipe_hazard_ctrl #(.MDU_LATENCY(L)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .id_valid          (id_valid),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rs        (id_uses_rs),
        .id_uses_rt        (id_uses_rt),
        .id_dest           (id_dest),
        .id_writes         (id_writes),
        .id_is_load        (id_is_load),
        .id_is_mdu         (id_is_mdu),
        .ex_stall_c        (ex_stall_c),
        .mem_stall_c       (mem_stall_c),
        .EX_MEM_changePC_c (EX_MEM_changePC_c),
        .WB_WEenable       (WB_WEenable),
        .WB_dest           (WB_dest),
        .if_stall_c        (if_stall_c),
        .id_bubble_c       (id_bubble_c),
        .flush_c           (flush_c),
        .mdu_busy          (mdu_busy),
        .sb_pending        (sb_pending),
        .hz_state          (hz_state)
`ifdef HAZARD_STATS_EN
        ,
        .stat_interlock_cycles (stat_interlock_cycles),
        .stat_flushes          (stat_flushes)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: pending set, edge counter, MDU free-edge, last issue edge
    bit          m_sb[32];
    int          cyc = 0;
    int          busy_end = 0;
    int          last_edge = -100;
    logic [4:0]  last_dest;
    bit          last_mdu;
    int          m_state = 0;
    longint      st_il = 0, st_fl = 0;
    bit          m_if, m_bub, m_fl, m_busy, m_haz, m_ext, m_issue;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic bit pend(input logic [4:0] r);
        return r != 5'd0 && m_sb[r] && !(WB_WEenable && WB_dest == r);
    endfunction

    function automatic void model_comb();
        bit raw, waw, st;
        m_busy = cyc < busy_end;
        raw = (id_uses_rs && pend(id_rs)) || (id_uses_rt && pend(id_rt));
        waw = id_writes && pend(id_dest);
        st = id_is_mdu && m_busy;
        m_haz = id_valid && (raw || waw || st);
        m_ext = ex_stall_c || mem_stall_c;
        m_fl = EX_MEM_changePC_c;
        m_if = !m_fl && (m_ext || m_haz);
        m_bub = !m_fl && !m_ext && m_haz;
        m_issue = id_valid && !m_fl && !m_ext && !m_haz;
    endfunction

    function automatic void model_edge();
        bit lv;
        int nst;
        model_comb();
        if (!reset_n) begin
            foreach (m_sb[r]) m_sb[r] = 1'b0;
            cyc++;
            busy_end = cyc;
            last_edge = -100;
            m_state = 0;
            st_il = 0;
            st_fl = 0;
            return;
        end
        lv = last_edge == cyc;
        nst = m_fl ? 3 : m_ext ? 2 : m_haz ? 1 : 0;
        cyc++;
        if (m_fl && lv) begin
            m_sb[last_dest] = 1'b0;
            if (last_mdu) busy_end = cyc;
        end
        if (WB_WEenable) m_sb[WB_dest] = 1'b0;
        if (m_issue && id_writes && (id_is_load || id_is_mdu) && id_dest != 5'd0) begin
            m_sb[id_dest] = 1'b1;
            last_edge = cyc;
            last_dest = id_dest;
            last_mdu = id_is_mdu;
        end
        if (m_issue && id_is_mdu) busy_end = cyc + L - 1;
        if (nst == 1 && st_il < 64'hFFFF_FFFF) st_il++;
        if (m_fl && st_fl < 64'hFFFF_FFFF) st_fl++;
        m_state = nst;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] e_sb;
        model_comb();
        for (int r = 0; r < 32; r++) e_sb[r] = m_sb[r];
        chk({tag, ".if_stall"}, 32'(if_stall_c), 32'(m_if));
        chk({tag, ".bubble"}, 32'(id_bubble_c), 32'(m_bub));
        chk({tag, ".flush"}, 32'(flush_c), 32'(m_fl));
        chk({tag, ".mdu_busy"}, 32'(mdu_busy), 32'(m_busy));
        chk({tag, ".sb_pending"}, sb_pending, e_sb);
        chk({tag, ".hz_state"}, 32'(hz_state), 32'(m_state));
`ifdef HAZARD_STATS_EN
        chk({tag, ".stat_il"}, stat_interlock_cycles, st_il[31:0]);
        chk({tag, ".stat_fl"}, stat_flushes, st_fl[31:0]);
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_dest = 0; id_writes = 0; id_is_load = 0; id_is_mdu = 0;
        ex_stall_c = 0; mem_stall_c = 0; EX_MEM_changePC_c = 0; WB_WEenable = 0; WB_dest = 0;
    endtask

    task automatic do_reset();
        clear_in();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    typedef struct {
        logic valid; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt; logic [4:0] dest;
        logic wr; logic ld; logic mdu; logic exs; logic mems; logic cpc; logic wbe; logic [4:0] wbd;
        logic e_if; logic e_bub; logic e_fl;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[6] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
        tbl[7] = '{1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 1, 4, 0, 0, 0};

        clear_in();
        reset_n = 0;
        tick();
        tick();

        // Table vectors held in reset: state stays clear, combinational outputs follow inputs
        for (int i = 0; i < 8; i++) begin
            id_valid = tbl[i].valid; id_rs = tbl[i].rs; id_rt = tbl[i].rt;
            id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; id_dest = tbl[i].dest;
            id_writes = tbl[i].wr; id_is_load = tbl[i].ld; id_is_mdu = tbl[i].mdu;
            ex_stall_c = tbl[i].exs; mem_stall_c = tbl[i].mems; EX_MEM_changePC_c = tbl[i].cpc;
            WB_WEenable = tbl[i].wbe; WB_dest = tbl[i].wbd;
            #1;
            chk($sformatf("tbl%0d.if_stall", i), 32'(if_stall_c), 32'(tbl[i].e_if));
            chk($sformatf("tbl%0d.bubble", i), 32'(id_bubble_c), 32'(tbl[i].e_bub));
            chk($sformatf("tbl%0d.flush", i), 32'(flush_c), 32'(tbl[i].e_fl));
            chk($sformatf("tbl%0d.sb_pending", i), sb_pending, 32'd0);
            chk($sformatf("tbl%0d.hz_state", i), 32'(hz_state), 32'd0);
            chk($sformatf("tbl%0d.mdu_busy", i), 32'(mdu_busy), 32'd0);
            tick();
        end

        // Load r5 then a reader of r5: stalls until the WB cycle
        do_reset();
        id_valid = 1; id_writes = 1; id_is_load = 1; id_dest = 5;
        #1; chk("ld5.issue_nostall", 32'(if_stall_c), 32'd0); step("ld5.c0");
        clear_in(); id_valid = 1; id_uses_rs = 1; id_rs = 5;
        #1; chk("ld5.stall", 32'(if_stall_c), 32'd1); chk("ld5.bubble", 32'(id_bubble_c), 32'd1);
        chk("ld5.pend", 32'(sb_pending[5]), 32'd1); step("ld5.c1");
        #1; chk("ld5.state_il", 32'(hz_state), 32'd1); chk("ld5.stall2", 32'(if_stall_c), 32'd1); step("ld5.c2");
        WB_WEenable = 1; WB_dest = 5;
        #1; chk("ld5.wb_nostall", 32'(if_stall_c), 32'd0); chk("ld5.wb_nobub", 32'(id_bubble_c), 32'd0); step("ld5.c3");
        clear_in();
        #1; chk("ld5.cleared", 32'(sb_pending[5]), 32'd0); step("ld5.c4");

        // Back-to-back MDU ops with L=4: second waits three cycles
        do_reset();
        id_valid = 1; id_writes = 1; id_is_mdu = 1; id_dest = 8;
        step("mdu.c0");
        id_dest = 9;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mdu.stall%0d", k), 32'(if_stall_c), 32'd1);
            chk($sformatf("mdu.busy%0d", k), 32'(mdu_busy), 32'd1);
            step("mdu.wait");
        end
        #1; chk("mdu.go_nostall", 32'(if_stall_c), 32'd0); chk("mdu.go_idle", 32'(mdu_busy), 32'd0); step("mdu.go");
        clear_in();
        #1; chk("mdu.busy_again", 32'(mdu_busy), 32'd1); chk("mdu.pend9", 32'(sb_pending[9]), 32'd1); step("mdu.after");

        // Load to r0 never pends nor stalls a reader of r0
        do_reset();
        id_valid = 1; id_writes = 1; id_is_load = 1; id_dest = 0;
        step("r0.c0");
        clear_in(); id_valid = 1; id_uses_rs = 1; id_uses_rt = 1;
        #1; chk("r0.nostall", 32'(if_stall_c), 32'd0); chk("r0.nopend", sb_pending, 32'd0); step("r0.c1");

        // Flush right after a load issue undoes its scoreboard bit
        do_reset();
        id_valid = 1; id_writes = 1; id_is_load = 1; id_dest = 7;
        step("fl.c0");
        clear_in(); EX_MEM_changePC_c = 1;
        #1; chk("fl.flush", 32'(flush_c), 32'd1); chk("fl.nostall", 32'(if_stall_c), 32'd0); step("fl.c1");
        clear_in();
        #1; chk("fl.cleared", 32'(sb_pending[7]), 32'd0); chk("fl.state", 32'(hz_state), 32'd3); step("fl.c2");
        id_valid = 1; id_writes = 1; id_is_mdu = 1; id_dest = 6;
        step("flm.c0");
        clear_in(); EX_MEM_changePC_c = 1;
        #1; chk("flm.busy", 32'(mdu_busy), 32'd1); step("flm.c1");
        clear_in();
        #1; chk("flm.idle", 32'(mdu_busy), 32'd0); chk("flm.cleared", 32'(sb_pending[6]), 32'd0); step("flm.c2");

        // External stall during a RAW hazard; WB still clears underneath
        do_reset();
        id_valid = 1; id_writes = 1; id_is_load = 1; id_dest = 9;
        step("ext.c0");
        clear_in(); id_valid = 1; id_uses_rt = 1; id_rt = 9; ex_stall_c = 1;
        #1; chk("ext.stall", 32'(if_stall_c), 32'd1); chk("ext.nobub", 32'(id_bubble_c), 32'd0); step("ext.c1");
        WB_WEenable = 1; WB_dest = 9;
        #1; chk("ext.state", 32'(hz_state), 32'd2); chk("ext.stall2", 32'(if_stall_c), 32'd1); step("ext.c2");
        ex_stall_c = 0; WB_WEenable = 0;
        #1; chk("ext.cleared", 32'(sb_pending[9]), 32'd0); chk("ext.released", 32'(if_stall_c), 32'd0); step("ext.c3");

        // Reset mid-stall drops every pending write
        do_reset();
        id_valid = 1; id_writes = 1; id_is_load = 1; id_dest = 4;
        step("rst.c0");
        clear_in(); id_valid = 1; id_uses_rs = 1; id_rs = 4;
        step("rst.c1");
        reset_n = 0;
        step("rst.c2");
        reset_n = 1;
        #1; chk("rst.nopend", sb_pending, 32'd0); chk("rst.nostall", 32'(if_stall_c), 32'd0);
        chk("rst.state", 32'(hz_state), 32'd0); step("rst.c3");

`ifdef HAZARD_STATS_EN
        do_reset();
        id_valid = 1; id_writes = 1; id_is_load = 1; id_dest = 5;
        step("st.c0");
        clear_in(); id_valid = 1; id_uses_rs = 1; id_rs = 5;
        for (int k = 0; k < 5; k++) step("st.il");
        EX_MEM_changePC_c = 1;
        step("st.fl0");
        step("st.fl1");
        clear_in();
        #1; chk("st.il5", stat_interlock_cycles, 32'd5); chk("st.fl2", stat_flushes, 32'd2); step("st.c1");
        do_reset();
        #1; chk("st.il0", stat_interlock_cycles, 32'd0); chk("st.fl0", stat_flushes, 32'd0); step("st.c2");
`endif

        // Random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset_n = $urandom_range(0, 99) != 0;
            id_valid = $urandom_range(0, 3) != 0;
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_dest = 5'($urandom_range(0, 7));
            id_writes = $urandom_range(0, 3) != 0;
            id_is_load = $urandom_range(0, 3) == 0;
            id_is_mdu = $urandom_range(0, 7) == 0;
            ex_stall_c = $urandom_range(0, 7) == 0;
            mem_stall_c = $urandom_range(0, 15) == 0;
            EX_MEM_changePC_c = $urandom_range(0, 9) == 0;
            WB_WEenable = $urandom_range(0, 2) == 0;
            WB_dest = 5'($urandom_range(0, 7));
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
